// File: rtl/sdm_ctrl_pkg.sv
// Shared types and constants for the SDM run controller.
package sdm_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      RUN   = 2'd2,
      CLEAR = 2'd3
   } state_t;

   // Gain is Q1.8 unsigned; 256 is unity.
   localparam int unsigned GAIN_W   = 9;
   localparam int unsigned GAIN_ONE = 256;

   // Quantizer end codes that indicate the loop is pinned.
   localparam logic signed [3:0] SAT_POS = 4'sb0111;
   localparam logic signed [3:0] SAT_NEG = 4'sb1000;

   function automatic logic is_sat(input logic signed [3:0] code);
      return (code == SAT_POS) || (code == SAT_NEG);
   endfunction

endpackage

// File: rtl/sdm_run_ctrl_if.sv
// Sample/code path between interpolator, controller, modulator and DAC.
interface sdm_run_ctrl_if;

   logic signed [15:0] din_16;
   logic signed [15:0] sdm_din;
   logic               sdm_rst_n;
   logic signed [3:0]  sdm_dout;
   logic signed [3:0]  dac_dout;

   modport master (
      input  din_16,
      input  sdm_dout,
      output sdm_din,
      output sdm_rst_n,
      output dac_dout
   );

   modport slave (
      output din_16,
      output sdm_dout,
      input  sdm_din,
      input  sdm_rst_n,
      input  dac_dout
   );

endinterface

// File: rtl/sdm_soft_gain.sv
// Registered soft-start gain stage: sdm_din = floor(din_16 * gain / 256).
module sdm_soft_gain
   import sdm_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [15:0]       din_16,
   input  logic        [GAIN_W-1:0] gain,
   output logic signed [15:0]       sdm_din
);

   logic signed [24:0] prod;

   // Gain is zero-extended so the product stays signed; 25 bits covers -32768 * 256.
   assign prod = 25'(din_16) * 25'($signed({1'b0, gain}));

   // Arithmetic shift floors toward -inf; the result always fits 16 bits for gain <= 256.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdm_din <= '0;
      end else begin
         sdm_din <= 16'(prod >>> 8);
      end
   end

endmodule

// File: rtl/sdm_run_ctrl.sv
// Sequencing and overload-protection controller for the 3rd-order CRFB modulator.
module sdm_run_ctrl
   import sdm_ctrl_pkg::*;
#(
   parameter int unsigned RAMP_DIV  = 64,
   parameter int unsigned OVL_LIMIT = 32,
   parameter int unsigned CLR_CYC   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   sdm_run_ctrl_if.master       bus,
   output logic [1:0]           state,
   output logic                 running,
   output logic                 ovl_irq,
   output logic [7:0]           ovl_cnt
);

   localparam int unsigned DivW = $clog2(RAMP_DIV);
   localparam int unsigned SatW = $clog2(OVL_LIMIT);
   localparam int unsigned ClrW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   localparam logic [DivW-1:0]   DivLast  = DivW'(RAMP_DIV - 1);
   localparam logic [SatW-1:0]   SatLast  = SatW'(OVL_LIMIT - 1);
   localparam logic [ClrW-1:0]   ClrLast  = ClrW'(CLR_CYC - 1);
   localparam logic [GAIN_W-1:0] GainLast = GAIN_W'(GAIN_ONE - 1);

   state_t            state_q;
   logic [GAIN_W-1:0] gain_q;
   logic [DivW-1:0]   div_cnt_q;
   logic [SatW-1:0]   sat_cnt_q;
   logic [ClrW-1:0]   clr_cnt_q;

   logic sat_code;
   logic trip;

   assign sat_code = is_sat(bus.sdm_dout);
   // The code arriving now would be the OVL_LIMIT-th consecutive saturated one.
   assign trip     = sat_code && (sat_cnt_q == SatLast);
   assign state    = state_q;

   // Control FSM with its counters and all registered control/gating outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         gain_q        <= '0;
         div_cnt_q     <= '0;
         sat_cnt_q     <= '0;
         clr_cnt_q     <= '0;
         bus.sdm_rst_n <= 1'b0;
         bus.dac_dout  <= '0;
         running       <= 1'b0;
         ovl_irq       <= 1'b0;
         ovl_cnt       <= '0;
      end else begin
         ovl_irq <= 1'b0;
         if (!en) begin
            // Disable wins over everything, including a trip on the same edge.
            state_q       <= IDLE;
            gain_q        <= '0;
            div_cnt_q     <= '0;
            sat_cnt_q     <= '0;
            clr_cnt_q     <= '0;
            bus.sdm_rst_n <= 1'b0;
            bus.dac_dout  <= '0;
            running       <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q       <= RAMP;
                  bus.sdm_rst_n <= 1'b1;
                  bus.dac_dout  <= '0;
                  gain_q        <= '0;
                  div_cnt_q     <= '0;
                  sat_cnt_q     <= '0;
               end
               RAMP, RUN: begin
                  bus.dac_dout <= bus.sdm_dout;
                  if (trip) begin
                     state_q       <= CLEAR;
                     ovl_irq       <= 1'b1;
                     if (ovl_cnt != 8'hFF) ovl_cnt <= ovl_cnt + 8'd1;
                     sat_cnt_q     <= '0;
                     clr_cnt_q     <= '0;
                     div_cnt_q     <= '0;
                     gain_q        <= '0;
                     bus.sdm_rst_n <= 1'b0;
                     running       <= 1'b0;
                  end else begin
                     sat_cnt_q <= sat_code ? sat_cnt_q + 1'b1 : '0;
                     if (state_q == RAMP) begin
                        if (div_cnt_q == DivLast) begin
                           div_cnt_q <= '0;
                           gain_q    <= gain_q + 1'b1;
                           if (gain_q == GainLast) begin
                              state_q <= RUN;
                              running <= 1'b1;
                           end
                        end else begin
                           div_cnt_q <= div_cnt_q + 1'b1;
                        end
                     end
                  end
               end
               CLEAR: begin
                  bus.dac_dout <= '0;
                  sat_cnt_q    <= '0;
                  if (clr_cnt_q == ClrLast) begin
                     state_q       <= RAMP;
                     bus.sdm_rst_n <= 1'b1;
                     clr_cnt_q     <= '0;
                     div_cnt_q     <= '0;
                     gain_q        <= '0;
                  end else begin
                     clr_cnt_q <= clr_cnt_q + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   sdm_soft_gain u_soft_gain (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_16  (bus.din_16),
      .gain    (gain_q),
      .sdm_din (bus.sdm_din)
   );

endmodule

// File: tb/tb_sdm_run_ctrl.sv
// Directed bench for sdm_run_ctrl with RAMP_DIV=4, OVL_LIMIT=32, CLR_CYC=16.
module tb_sdm_run_ctrl;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [1:0] state;
   logic       running;
   logic       ovl_irq;
   logic [7:0] ovl_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int irq_seen    = 0;
   int irq_mark;

   sdm_run_ctrl_if bus ();

   sdm_run_ctrl #(
      .RAMP_DIV  (4),
      .OVL_LIMIT (32),
      .CLR_CYC   (16)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .bus     (bus),
      .state   (state),
      .running (running),
      .ovl_irq (ovl_irq),
      .ovl_cnt (ovl_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, sampling 1 time unit after each and tallying irq pulses.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (ovl_irq === 1'b1) irq_seen++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      en           = 1'b0;
      bus.din_16   = '0;
      bus.sdm_dout = '0;
      step(3);
      rst_n = 1'b1;
      step(1);
      chk("rst_state", 32'(state), 0);
      chk("rst_sdm_rst_n", 32'(bus.sdm_rst_n), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_ovl_cnt", 32'(ovl_cnt), 0);
      chk("rst_dac", bus.dac_dout, 0);
      chk("rst_sdm_din", bus.sdm_din, 0);

      // Soft start: RAMP entry edge is R0.
      bus.din_16 = 16'sd16384;
      en         = 1'b1;
      step(1);
      chk("ramp_entry_state", 32'(state), 1);
      chk("ramp_entry_rst_n", 32'(bus.sdm_rst_n), 1);
      step(513);
      chk("ramp_half_gain", bus.sdm_din, 8192);
      chk("ramp_half_state", 32'(state), 1);
      step(510);
      chk("pre_run_running", 32'(running), 0);
      chk("pre_run_state", 32'(state), 1);
      step(1);
      chk("run_running", 32'(running), 1);
      chk("run_state", 32'(state), 2);
      chk("run_last_ramp", bus.sdm_din, 16320);
      step(1);
      chk("run_unity", bus.sdm_din, 16384);

      // Negative scaling and output gating in RUN.
      bus.din_16 = -16'sd32768;
      step(1);
      chk("neg_full_scale", bus.sdm_din, -32768);
      bus.din_16 = -16'sd1;
      step(1);
      chk("neg_one_unity", bus.sdm_din, -1);
      bus.sdm_dout = 4'sd3;
      step(1);
      chk("dac_pos", bus.dac_dout, 3);
      bus.sdm_dout = -4'sd5;
      step(1);
      chk("dac_neg", bus.dac_dout, -5);

      // 31 mixed saturated, a break, 31 more: must not trip.
      irq_mark = irq_seen;
      for (int i = 0; i < 31; i++) begin
         bus.sdm_dout = (i % 2 == 0) ? 4'sd7 : -4'sd8;
         step(1);
      end
      bus.sdm_dout = 4'sd0;
      step(1);
      for (int i = 0; i < 31; i++) begin
         bus.sdm_dout = (i % 2 == 0) ? -4'sd8 : 4'sd7;
         step(1);
      end
      bus.sdm_dout = 4'sd0;
      step(1);
      chk("notrip_irqs", 32'(irq_seen - irq_mark), 0);
      chk("notrip_state", 32'(state), 2);

      // 32 consecutive +7 codes trip into CLEAR (trip edge T0).
      bus.sdm_dout = 4'sd7;
      step(31);
      chk("trip_pre_state", 32'(state), 2);
      step(1);
      chk("trip_irq", 32'(ovl_irq), 1);
      chk("trip_state", 32'(state), 3);
      chk("trip_ovl_cnt", 32'(ovl_cnt), 1);
      chk("trip_rst_n", 32'(bus.sdm_rst_n), 0);
      chk("trip_running", 32'(running), 0);
      bus.sdm_dout = 4'sd0;
      step(1);
      chk("trip_irq_pulse", 32'(ovl_irq), 0);
      chk("clear_dac", bus.dac_dout, 0);
      step(14);
      chk("clear_t15_rst_n", 32'(bus.sdm_rst_n), 0);
      chk("clear_t15_state", 32'(state), 3);
      step(1);
      chk("clear_done_rst_n", 32'(bus.sdm_rst_n), 1);
      chk("clear_done_state", 32'(state), 1);
      step(4);
      chk("reramp_gain0", bus.sdm_din, 0);
      step(1);
      chk("reramp_gain1_floor", bus.sdm_din, -1);
      chk("trip_irq_count", 32'(irq_seen - irq_mark), 1);

      // Enable drop mid-RAMP.
      bus.sdm_dout = 4'sd5;
      en           = 1'b0;
      step(1);
      chk("endrop_ramp_state", 32'(state), 0);
      chk("endrop_ramp_rst_n", 32'(bus.sdm_rst_n), 0);
      chk("endrop_ramp_dac", bus.dac_dout, 0);

      // Trip from RAMP, then enable drop mid-CLEAR.
      en           = 1'b1;
      bus.sdm_dout = 4'sd7;
      step(33);
      chk("ramp_trip_state", 32'(state), 3);
      chk("ramp_trip_ovl_cnt", 32'(ovl_cnt), 2);
      en = 1'b0;
      step(1);
      chk("endrop_clear_state", 32'(state), 0);
      chk("endrop_clear_rst_n", 32'(bus.sdm_rst_n), 0);
      chk("endrop_clear_dac", bus.dac_dout, 0);

      // Enable drop on the same edge as the 32nd saturated code.
      en           = 1'b1;
      bus.sdm_dout = 4'sd0;
      step(1);
      irq_mark     = irq_seen;
      bus.sdm_dout = 4'sd7;
      step(31);
      en = 1'b0;
      step(1);
      chk("endrop_trip_state", 32'(state), 0);
      chk("endrop_trip_ovl_cnt", 32'(ovl_cnt), 2);
      chk("endrop_trip_irqs", 32'(irq_seen - irq_mark), 0);

      // 300 back-to-back trips, 48 cycles apiece: counter pins at 255.
      irq_mark = irq_seen;
      en       = 1'b1;
      step(14400);
      chk("burst_irqs", 32'(irq_seen - irq_mark), 300);
      chk("burst_ovl_cnt_sat", 32'(ovl_cnt), 255);
      en           = 1'b0;
      bus.sdm_dout = 4'sd0;
      step(1);
      chk("burst_idle", 32'(state), 0);

      // Asynchronous reset mid-RAMP, checked before any further edge.
      bus.din_16 = 16'sd16384;
      en         = 1'b1;
      step(101);
      chk("pre_areset_sdm_din", bus.sdm_din, 1536);
      chk("pre_areset_ovl_cnt", 32'(ovl_cnt), 255);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_state", 32'(state), 0);
      chk("areset_sdm_din", bus.sdm_din, 0);
      chk("areset_rst_n", 32'(bus.sdm_rst_n), 0);
      chk("areset_dac", bus.dac_dout, 0);
      chk("areset_running", 32'(running), 0);
      chk("areset_ovl_cnt", 32'(ovl_cnt), 0);
      chk("areset_irq", 32'(ovl_irq), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
